// File: rtl/countdown_timer_if.sv
// Control and status bundle between the button/tick front end and the
// countdown_timer core. The master side drives controls and watches status;
// the slave side is the timer itself.
interface countdown_timer_if;
  logic        tick;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic [15:0] count_bcd;
  logic        running;
  logic        expired;
  logic        done;

  modport master (
    output tick, load, load_value, start, stop,
    input  count_bcd, running, expired, done
  );

  modport slave (
    input  tick, load, load_value, start, stop,
    output count_bcd, running, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer. Counts down one second per TICKS_PER_STEP tick
// strobes while running, pauses/resumes on stop/start, and flags expiry with a
// one-cycle done pulse plus an expired level held until the next load.
// Reset is asserted asynchronously and released through a two-flop
// synchroniser so that no state leaves reset on a partial clock cycle.
module countdown_timer #(
  parameter int unsigned TICKS_PER_STEP = 32'd1
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_STEP - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Limit a BCD digit to max_d (covers both non-BCD codes and >5 tens-of-seconds).
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    logic [3:0] r;
    if (d > max_d) begin
      r = max_d;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Force every digit of a loaded value into a legal MM:SS range.
  function automatic logic [15:0] sanitise_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12], 4'd9),
            clamp_digit(v[11:8],  4'd9),
            clamp_digit(v[7:4],   4'd5),
            clamp_digit(v[3:0],   4'd9)};
  endfunction

  // One-second decrement with the MM:SS borrow chain; 00:00 saturates.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    mt = v[15:12];
    mo = v[11:8];
    st = v[7:4];
    so = v[3:0];
    if (v == 16'h0000) begin
      so = 4'd0;
    end else if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  logic        rst_meta_q;
  logic        rst_ok_q;

  state_t      state_q,   state_d;
  logic [15:0] count_q,   count_d;
  logic [7:0]  presc_q,   presc_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        done_q,    done_d;
  logic [15:0] count_dec_s;

  // Reset synchroniser: async assert, release after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_ok_q   <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_ok_q   <= rst_meta_q;
    end
  end

  // Next-state logic; priority load > stop > start > tick.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_d     = presc_q;
    done_d      = 1'b0;
    count_dec_s = dec_bcd(count_q);

    if (!rst_ok_q) begin
      state_d = ST_IDLE;
      count_d = 16'h0000;
      presc_d = 8'd0;
    end else if (bus.load) begin
      state_d = ST_IDLE;
      count_d = sanitise_bcd(bus.load_value);
      presc_d = 8'd0;
    end else if (bus.stop && (state_q == ST_RUN)) begin
      // Prescaler is frozen so a resume finishes the partial second.
      state_d = ST_PAUSED;
    end else if (bus.start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      if (count_q != 16'h0000) begin
        state_d = ST_RUN;
        // A fresh start begins a whole second; a resume keeps the partial one.
        if (state_q == ST_IDLE) begin
          presc_d = 8'd0;
        end else begin
          presc_d = presc_q;
        end
      end else begin
        state_d = state_q;
      end
    end else if (bus.tick && (state_q == ST_RUN)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = 8'd0;
        count_d = count_dec_s;
        if (count_dec_s == 16'h0000) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end else begin
      state_d = state_q;
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_DONE);
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= 16'h0000;
      presc_q   <= 8'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.running   = running_q;
  assign bus.expired   = expired_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (1 and 4 ticks per second) share
// stimulus; a seconds-based reference model pushes expected outputs into a
// scoreboard queue that is popped and compared after each clock edge.
module tb_countdown_timer;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUS = 2;
  localparam int S_DONE = 3;

  typedef struct {
    int secs;
    int st;
    int presc;
    bit done;
  } mdl_t;

  typedef struct {
    logic [15:0] cnt;
    bit          run;
    bit          expd;
    bit          dn;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  mdl_t m1;
  mdl_t m4;
  exp_t q1[$];
  exp_t q4[$];

  countdown_timer_if bus1();
  countdown_timer_if bus4();

  countdown_timer #(.TICKS_PER_STEP(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  countdown_timer #(.TICKS_PER_STEP(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  function automatic int lim(input int d, input int mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic int load_secs(input logic [15:0] v);
    int mt, mo, st, so;
    mt = lim(int'(v[15:12]), 9);
    mo = lim(int'(v[11:8]), 9);
    st = lim(int'(v[7:4]), 5);
    so = lim(int'(v[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    logic [3:0] a, b, c, d;
    m = secs / 60;
    s = secs % 60;
    a = 4'(m / 10);
    b = 4'(m % 10);
    c = 4'(s / 10);
    d = 4'(s % 10);
    return {a, b, c, d};
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int tps, input bit tk, input bit ld,
                                    input logic [15:0] lv, input bit sa, input bit so);
    mdl_t r;
    r = m;
    r.done = 1'b0;
    if (ld) begin
      r.secs  = load_secs(lv);
      r.st    = S_IDLE;
      r.presc = 0;
    end else if (so && m.st == S_RUN) begin
      r.st = S_PAUS;
    end else if (sa && (m.st == S_IDLE || m.st == S_PAUS)) begin
      if (m.secs != 0) begin
        if (m.st == S_IDLE) r.presc = 0;
        r.st = S_RUN;
      end
    end else if (tk && m.st == S_RUN) begin
      if (m.presc == tps - 1) begin
        r.presc = 0;
        r.secs  = m.secs - 1;
        if (r.secs == 0) begin
          r.st   = S_DONE;
          r.done = 1'b1;
        end
      end else begin
        r.presc = m.presc + 1;
      end
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input mdl_t m);
    exp_t e;
    e.cnt  = to_bcd(m.secs);
    e.run  = (m.st == S_RUN);
    e.expd = (m.st == S_DONE);
    e.dn   = m.done;
    return e;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.secs = 0; r.st = S_IDLE; r.presc = 0; r.done = 1'b0;
    return r;
  endfunction

  task automatic drive(input bit tk, input bit ld, input logic [15:0] lv, input bit sa, input bit so);
    bus1.tick = tk; bus1.load = ld; bus1.load_value = lv; bus1.start = sa; bus1.stop = so;
    bus4.tick = tk; bus4.load = ld; bus4.load_value = lv; bus4.start = sa; bus4.stop = so;
  endtask

  // One clock of stimulus: drive, predict, then compare after the edge.
  task automatic cyc(input bit tk, input bit ld, input logic [15:0] lv, input bit sa, input bit so);
    exp_t e;
    drive(tk, ld, lv, sa, so);
    m1 = mdl_step(m1, 1, tk, ld, lv, sa, so);
    q1.push_back(mk_exp(m1));
    m4 = mdl_step(m4, 4, tk, ld, lv, sa, so);
    q4.push_back(mk_exp(m4));
    @(posedge clk);
    #1;
    e = q1.pop_front();
    check_val("d1_cnt", 32'(bus1.count_bcd), 32'(e.cnt));
    check_val("d1_run", 32'(bus1.running), 32'(e.run));
    check_val("d1_exp", 32'(bus1.expired), 32'(e.expd));
    check_val("d1_done", 32'(bus1.done), 32'(e.dn));
    e = q4.pop_front();
    check_val("d4_cnt", 32'(bus4.count_bcd), 32'(e.cnt));
    check_val("d4_run", 32'(bus4.running), 32'(e.run));
    check_val("d4_exp", 32'(bus4.expired), 32'(e.expd));
    check_val("d4_done", 32'(bus4.done), 32'(e.dn));
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_cnt1"}, 32'(bus1.count_bcd), 32'h0);
    check_val({tag, "_run1"}, 32'(bus1.running), 32'h0);
    check_val({tag, "_exp1"}, 32'(bus1.expired), 32'h0);
    check_val({tag, "_done1"}, 32'(bus1.done), 32'h0);
    check_val({tag, "_cnt4"}, 32'(bus4.count_bcd), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m1 = mdl_reset();
    m4 = mdl_reset();
    q1.delete();
    q4.delete();
  endtask

  initial begin
    int n_done;
    int done_at;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_reset();
    check_zero("post_rst");

    // 01:30 run to expiry with back-to-back ticks.
    cyc(0, 1, 16'h0130, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    n_done = 0;
    for (int i = 0; i < 90; i++) begin
      cyc(1, 0, 16'h0000, 0, 0);
      if (bus1.done) n_done++;
    end
    check_val("t90_cnt", 32'(bus1.count_bcd), 32'h0000);
    check_val("t90_exp", 32'(bus1.expired), 32'h1);
    check_val("t90_run", 32'(bus1.running), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 16'h0000, 1, 0);
      if (bus1.done) n_done++;
    end
    check_val("t90_done_cnt", 32'(n_done), 32'd1);

    // Borrow chain across minutes.
    cyc(0, 1, 16'h1000, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    check_val("borrow_1000", 32'(bus1.count_bcd), 32'h0959);
    cyc(0, 1, 16'h0100, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    check_val("borrow_0100", 32'(bus1.count_bcd), 32'h0059);

    // Sanitising and start at zero.
    cyc(0, 1, 16'h7A7C, 0, 0);
    check_val("sanitise", 32'(bus1.count_bcd), 32'h7959);
    cyc(0, 1, 16'h0000, 0, 0);
    cyc(1, 0, 16'h0000, 1, 0);
    check_val("zero_start_run", 32'(bus1.running), 32'h0);
    cyc(1, 0, 16'h0000, 0, 0);
    check_val("zero_start_done", 32'(bus1.done), 32'h0);

    // Stop beats a same-cycle tick; ticks ignored while paused.
    cyc(0, 1, 16'h0005, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 1);
    check_val("stop_tick_cnt", 32'(bus1.count_bcd), 32'h0005);
    check_val("stop_tick_run", 32'(bus1.running), 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0000, 0, 0);
    check_val("paused_cnt", 32'(bus1.count_bcd), 32'h0005);
    cyc(1, 0, 16'h0000, 1, 1);
    cyc(1, 0, 16'h0000, 0, 0);
    check_val("resume_cnt", 32'(bus1.count_bcd), 32'h0004);

    // Prescaler of 4: done on the 8th tick.
    cyc(0, 1, 16'h0002, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    done_at = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 16'h0000, 0, 0);
      if (bus4.done) done_at = i + 1;
    end
    check_val("p4_done_at", 32'(done_at), 32'd8);
    check_val("p4_cnt", 32'(bus4.count_bcd), 32'h0000);

    // Prescaler of 4: pause mid-second, resume completes it with 2 more ticks.
    cyc(0, 1, 16'h0002, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1);
    cyc(1, 0, 16'h0000, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    check_val("p4_partial", 32'(bus4.count_bcd), 32'h0002);
    cyc(1, 0, 16'h0000, 0, 0);
    check_val("p4_resume", 32'(bus4.count_bcd), 32'h0001);

    // Load during RUN.
    cyc(0, 1, 16'h0030, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    cyc(1, 1, 16'h0045, 0, 0);
    check_val("load_run_cnt", 32'(bus1.count_bcd), 32'h0045);
    check_val("load_run_run", 32'(bus1.running), 32'h0);

    // Randomised mix against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] lv;
      lv = 16'($urandom);
      if ($urandom_range(0, 1) == 0) lv = lv & 16'h001F;
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), lv,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a run.
    cyc(0, 1, 16'h0100, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0000, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    do_reset();
    cyc(1, 0, 16'h0000, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
